// File: rtl/iter_alu.sv
// Sequential EX-stage ALU: registered single-cycle ops, iterative or fast multiply,
// restoring divide and the architectural HI/LO pair with move-to/from access.
module iter_alu #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alu_func,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               SHW      = $clog2(WIDTH);
  localparam int               DW       = 2 * WIDTH;
  localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [DW-1:0]    ONE_2W   = DW'(1);

  localparam logic [5:0] F_ADD  = 6'd0,  F_ADDU = 6'd1,  F_SUB  = 6'd2,  F_SUBU = 6'd3;
  localparam logic [5:0] F_AND  = 6'd4,  F_OR   = 6'd5,  F_XOR  = 6'd6,  F_NOR  = 6'd7;
  localparam logic [5:0] F_SLT  = 6'd8,  F_SLTU = 6'd9,  F_SLL  = 6'd10, F_SRL  = 6'd11;
  localparam logic [5:0] F_SRA  = 6'd12, F_SLLV = 6'd13, F_SRLV = 6'd14, F_SRAV = 6'd15;
  localparam logic [5:0] F_LUI  = 6'd16, F_MULT = 6'd17, F_MULTU = 6'd18, F_DIV = 6'd19;
  localparam logic [5:0] F_DIVU = 6'd20, F_MFHI = 6'd21, F_MFLO = 6'd22, F_MTHI = 6'd23;
  localparam logic [5:0] F_MTLO = 6'd24;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, carry_q, carry_d, negative_q, negative_d;
  logic             overflow_q, overflow_d, div_zero_q, div_zero_d;

  logic             accept, is_mul, is_div, is_signed, a_neg, b_neg, last_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_full, sub_full;
  logic             add_ovf, sub_ovf, slt_s, slt_u;
  logic [SHW-1:0]   sh_amt;
  logic [DW-1:0]    fast_prod;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [DW-1:0]    mul_step, div_step, mul_final;
  logic [WIDTH-1:0] quo_final, rem_final;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf, sc_known;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign is_mul    = (alu_func == F_MULT) || (alu_func == F_MULTU);
  assign is_div    = (alu_func == F_DIV) || (alu_func == F_DIVU);
  assign is_signed = (alu_func == F_MULT) || (alu_func == F_DIV);
  assign a_neg     = is_signed && a[WIDTH-1];
  assign b_neg     = is_signed && b[WIDTH-1];
  assign mag_a     = a_neg ? (~a + ONE_W) : a;
  assign mag_b     = b_neg ? (~b + ONE_W) : b;
  assign last_step = (cnt_q == LAST_CNT);

  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};
  assign add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
  assign slt_s     = $signed(a) < $signed(b);
  assign slt_u     = a < b;
  assign sh_amt    = a[SHW-1:0];
  assign fast_prod = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};

  // Shift-add multiply: acc holds {partial product, remaining multiplier bits}
  assign mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_final = qneg_q ? (~mul_step + ONE_2W) : mul_step;

  // Restoring divide: acc holds {remainder, dividend bits shifting into quotient}
  assign rem_sh    = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge    = rem_sh >= {1'b0, mag_q};
  assign rem_sub   = rem_sh[WIDTH-1:0] - mag_q;
  assign div_step  = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign quo_final = qneg_q ? (~div_step[WIDTH-1:0] + ONE_W) : div_step[WIDTH-1:0];
  assign rem_final = rneg_q ? (~div_step[DW-1:WIDTH] + ONE_W) : div_step[DW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      res_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mag_q      <= mag_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      res_q      <= res_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul && !FAST_MUL)       state_d = S_MUL;
          else if (is_div && (b != '0))  state_d = S_DIV;
          else                           state_d = S_DONE;
        end
      end
      S_MUL, S_DIV: if (last_step) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    res       = res_q;
    zero      = zero_q;
    carry     = carry_q;
    negative  = negative_q;
    overflow  = overflow_q;
    div_zero  = div_zero_q;
    hi        = hi_q;
    lo        = lo_q;
  end

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_known = 1'b1;
    case (alu_func)
      F_ADD:           begin sc_res = add_full[WIDTH-1:0]; sc_carry = add_full[WIDTH]; sc_ovf = add_ovf; end
      F_ADDU:          begin sc_res = add_full[WIDTH-1:0]; sc_carry = add_full[WIDTH]; end
      F_SUB:           begin sc_res = sub_full[WIDTH-1:0]; sc_carry = sub_full[WIDTH]; sc_ovf = sub_ovf; end
      F_SUBU:          begin sc_res = sub_full[WIDTH-1:0]; sc_carry = sub_full[WIDTH]; end
      F_AND:           sc_res = a & b;
      F_OR:            sc_res = a | b;
      F_XOR:           sc_res = a ^ b;
      F_NOR:           sc_res = ~(a | b);
      F_SLT:           sc_res = {{(WIDTH-1){1'b0}}, slt_s};
      F_SLTU:          sc_res = {{(WIDTH-1){1'b0}}, slt_u};
      F_SLL, F_SLLV:   sc_res = b << sh_amt;
      F_SRL, F_SRLV:   sc_res = b >> sh_amt;
      F_SRA, F_SRAV:   sc_res = $signed(b) >>> sh_amt;
      F_LUI:           sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      F_MULT, F_MULTU: sc_res = fast_prod[WIDTH-1:0];
      F_DIV, F_DIVU:   sc_res = '1;
      F_MFHI:          sc_res = hi_q;
      F_MFLO:          sc_res = lo_q;
      F_MTHI, F_MTLO:  sc_res = a;
      default:         sc_known = 1'b0;
    endcase
  end

  // Single-cycle results land at the accept edge; iterative ones at their last step
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mag_d      = mag_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    res_d      = res_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      cnt_d      = '0;
      acc_d      = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      mag_d      = is_div ? mag_b : mag_a;
      qneg_d     = a_neg ^ b_neg;
      rneg_d     = a_neg;
      res_d      = sc_res;
      zero_d     = sc_known && (sc_res == '0);
      negative_d = sc_res[WIDTH-1];
      carry_d    = sc_carry;
      overflow_d = sc_ovf;
      div_zero_d = is_div && (b == '0);
      if (is_mul && FAST_MUL) begin
        hi_d = fast_prod[DW-1:WIDTH];
        lo_d = fast_prod[WIDTH-1:0];
      end
      if (is_div && (b == '0)) begin
        hi_d = a;
        lo_d = '1;
      end
      if (alu_func == F_MTHI) hi_d = a;
      if (alu_func == F_MTLO) lo_d = a;
    end else if (state_q == S_MUL) begin
      acc_d = mul_step;
      cnt_d = cnt_q + SHW'(1);
      if (last_step) begin
        hi_d       = mul_final[DW-1:WIDTH];
        lo_d       = mul_final[WIDTH-1:0];
        res_d      = mul_final[WIDTH-1:0];
        zero_d     = (mul_final[WIDTH-1:0] == '0);
        negative_d = mul_final[WIDTH-1];
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        div_zero_d = 1'b0;
      end
    end else if (state_q == S_DIV) begin
      acc_d = div_step;
      cnt_d = cnt_q + SHW'(1);
      if (last_step) begin
        hi_d       = rem_final;
        lo_d       = quo_final;
        res_d      = quo_final;
        zero_d     = (quo_final == '0);
        negative_d = quo_final[WIDTH-1];
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        div_zero_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: a 32-bit iterative-multiply instance driven through
// a reference model, plus a 16-bit fast-multiply instance with directed checks.
module tb_iter_alu;

  localparam logic [5:0] F_ADD  = 6'd0,  F_ADDU = 6'd1,  F_SUB  = 6'd2,  F_SUBU = 6'd3;
  localparam logic [5:0] F_AND  = 6'd4,  F_OR   = 6'd5,  F_XOR  = 6'd6,  F_NOR  = 6'd7;
  localparam logic [5:0] F_SLT  = 6'd8,  F_SLTU = 6'd9,  F_SLL  = 6'd10, F_SRL  = 6'd11;
  localparam logic [5:0] F_SRA  = 6'd12, F_SLLV = 6'd13, F_SRLV = 6'd14, F_SRAV = 6'd15;
  localparam logic [5:0] F_LUI  = 6'd16, F_MULT = 6'd17, F_MULTU = 6'd18, F_DIV = 6'd19;
  localparam logic [5:0] F_DIVU = 6'd20, F_MFHI = 6'd21, F_MFLO = 6'd22, F_MTHI = 6'd23;
  localparam logic [5:0] F_MTLO = 6'd24;

  typedef struct {
    logic [31:0] res;
    logic        z, c, n, v, dz;
    logic [31:0] hi, lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid;
  logic [31:0] a, b, res, hi, lo;
  logic [5:0]  alu_func;
  logic        zero, carry, negative, overflow, div_zero;

  logic        s_in_valid, s_in_ready, s_out_valid;
  logic [15:0] s_a, s_b, s_res, s_hi, s_lo;
  logic [5:0]  s_func;
  logic        s_zero, s_carry, s_negative, s_overflow, s_div_zero;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mHi = '0, mLo = '0;
  exp_t        expQ[$];
  string       tagQ[$];

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_func(alu_func), .out_valid(out_valid), .res(res),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  iter_alu #(.WIDTH(16), .FAST_MUL(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .alu_func(s_func), .out_valid(s_out_valid), .res(s_res),
    .zero(s_zero), .carry(s_carry), .negative(s_negative), .overflow(s_overflow),
    .div_zero(s_div_zero), .hi(s_hi), .lo(s_lo)
  );

  // Reference model built on 64-bit integer arithmetic rather than bit-level tricks
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, y,
                                 input logic [31:0] h, l);
    exp_t e;
    longint sx, sy, t, r;
    longint unsigned ux, uy, up;
    logic known;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = x;
    uy = y;
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0;
    e.hi = h; e.lo = l; e.lat = 1; known = 1'b1;
    case (f)
      F_ADD:  begin t = sx + sy; e.res = t[31:0]; up = ux + uy; e.c = up[32];
                    e.v = (t != longint'(signed'(t[31:0]))); end
      F_ADDU: begin up = ux + uy; e.res = up[31:0]; e.c = up[32]; end
      F_SUB:  begin t = sx - sy; e.res = t[31:0]; e.c = (x < y);
                    e.v = (t != longint'(signed'(t[31:0]))); end
      F_SUBU: begin e.res = x - y; e.c = (x < y); end
      F_AND:  e.res = x & y;
      F_OR:   e.res = x | y;
      F_XOR:  e.res = x ^ y;
      F_NOR:  e.res = ~(x | y);
      F_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      F_SLTU: e.res = (ux < uy) ? 32'd1 : 32'd0;
      F_SLL, F_SLLV: e.res = y << x[4:0];
      F_SRL, F_SRLV: e.res = y >> x[4:0];
      F_SRA, F_SRAV: e.res = signed'(y) >>> x[4:0];
      F_LUI:  e.res = {y[15:0], 16'h0000};
      F_MULT: begin t = sx * sy; e.hi = t[63:32]; e.lo = t[31:0]; e.res = t[31:0]; e.lat = 33; end
      F_MULTU: begin up = ux * uy; e.hi = up[63:32]; e.lo = up[31:0]; e.res = up[31:0]; e.lat = 33; end
      F_DIV, F_DIVU: begin
        if (y == 32'd0) begin
          e.dz = 1'b1; e.lo = '1; e.hi = x; e.res = '1;
        end else begin
          if (f == F_DIV) begin t = sx / sy; r = sx % sy; end
          else begin t = longint'(ux / uy); r = longint'(ux % uy); end
          e.lo = t[31:0]; e.hi = r[31:0]; e.res = t[31:0]; e.lat = 33;
        end
      end
      F_MFHI: e.res = h;
      F_MFLO: e.res = l;
      F_MTHI: begin e.res = x; e.hi = x; end
      F_MTLO: begin e.res = x; e.lo = x; end
      default: known = 1'b0;
    endcase
    e.z = known && (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [5:0] f, input logic [31:0] x, y);
    exp_t e;
    e = model(f, x, y, mHi, mLo);
    mHi = e.hi;
    mLo = e.lo;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Drives one op for a single accept edge, then scrambles inputs to prove capture
  task automatic applyStimulus(input string tag, input logic [5:0] f, input logic [31:0] x, y);
    pushExpected(tag, f, x, y);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; alu_func = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_func = 6'($urandom_range(0, 24));
  endtask

  // Called just after the accept edge; counts edges until out_valid is seen
  task automatic checkOutput();
    exp_t  e;
    string t;
    int    lat;
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    checkValue("scoreboard depth", 64'(expQ.size()), 64'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkValue({t, " latency"}, 64'(lat), 64'(e.lat));
      checkValue({t, " res"}, res, e.res);
      checkValue({t, " flags zcnvd"}, {zero, carry, negative, overflow, div_zero},
                 {e.z, e.c, e.n, e.v, e.dz});
      checkValue({t, " hi"}, hi, e.hi);
      checkValue({t, " lo"}, lo, e.lo);
    end
  endtask

  task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] x, y);
    applyStimulus(tag, f, x, y);
    checkOutput();
  endtask

  task automatic run16(input string tag, input logic [5:0] f, input logic [15:0] x, y,
                       input logic [15:0] eRes, eHi, eLo, input int eLat);
    int lat;
    lat = 1;
    @(negedge clk);
    s_in_valid = 1'b1; s_a = x; s_b = y; s_func = f;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom);
    while (lat < 100) begin
      @(negedge clk);
      if (s_out_valid) break;
      lat++;
    end
    checkValue({tag, " latency"}, 64'(lat), 64'(eLat));
    checkValue({tag, " res"}, s_res, eRes);
    checkValue({tag, " hi"}, s_hi, eHi);
    checkValue({tag, " lo"}, s_lo, eLo);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int ovSeen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_func = '0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_func = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkValue("reset in_ready", in_ready, 1'b1);
    checkValue("reset out_valid", out_valid, 1'b0);
    checkValue("reset res", res, 32'd0);
    checkValue("reset flags", {zero, carry, negative, overflow, div_zero}, 5'b0);
    checkValue("reset hi", hi, 32'd0);
    checkValue("reset lo", lo, 32'd0);

    run16("w16 fast mult", F_MULT, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 16'hFFF1, 1);
    run16("w16 srav", F_SRAV, 16'h0013, 16'h8000, 16'hF000, 16'hFFFF, 16'hFFF1, 1);
    run16("w16 div", F_DIV, 16'd100, 16'd7, 16'd14, 16'd2, 16'd14, 17);

    runOp("add ovf", F_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    runOp("addu carry", F_ADDU, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("sub borrow", F_SUB, 32'd3, 32'd5);
    runOp("sub ovf", F_SUB, 32'h8000_0000, 32'h0000_0001);
    runOp("subu equal", F_SUBU, 32'd5, 32'd5);
    runOp("and", F_AND, 32'hF0F0_1234, 32'h0FF0_5678);
    runOp("or", F_OR, 32'hF0F0_1234, 32'h0FF0_5678);
    runOp("xor", F_XOR, 32'hF0F0_1234, 32'h0FF0_5678);
    runOp("nor", F_NOR, 32'hF0F0_1234, 32'h0FF0_5678);
    runOp("slt", F_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("sltu", F_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("sll masked", F_SLL, 32'h0000_0024, 32'h8000_0001);
    runOp("srl", F_SRL, 32'h0000_0004, 32'h8000_0000);
    runOp("sra", F_SRA, 32'h0000_0004, 32'h8000_0010);
    runOp("sllv", F_SLLV, 32'h0000_001F, 32'h0000_0001);
    runOp("srlv", F_SRLV, 32'h0000_0000, 32'hDEAD_BEEF);
    runOp("srav pos", F_SRAV, 32'h0000_0003, 32'h7000_0000);
    runOp("lui", F_LUI, 32'h0000_0000, 32'hABCD_1234);
    runOp("undefined", 6'd30, 32'h1234_5678, 32'h9ABC_DEF0);
    runOp("mult", F_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    runOp("mfhi", F_MFHI, 32'h0, 32'h0);
    runOp("mflo", F_MFLO, 32'h0, 32'h0);
    runOp("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    runOp("div negdiv", F_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    runOp("div minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("divu zero", F_DIVU, 32'h0000_0007, 32'h0000_0000);
    runOp("divu", F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    runOp("mthi", F_MTHI, 32'h0000_1234, 32'h0);
    runOp("mtlo", F_MTLO, 32'h0000_5678, 32'h0);
    runOp("mfhi after mt", F_MFHI, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++)
      runOp("rand", 6'($urandom_range(0, 16)), $urandom, $urandom);

    // MULTU with in_valid held high; the following MFLO must wait for IDLE
    pushExpected("b2b multu", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0003);
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0003; alu_func = F_MULTU;
    @(posedge clk);
    #1;
    alu_func = F_MFLO; a = $urandom; b = $urandom;
    checkOutput();
    checkValue("b2b busy in_ready", in_ready, 1'b0);
    pushExpected("b2b mflo", F_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    checkValue("b2b idle in_ready", in_ready, 1'b1);
    checkValue("b2b idle out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput();

    // Reset lands mid-divide; the aborted op must never report
    @(negedge clk);
    in_valid = 1'b1; a = 32'd100; b = 32'd7; alu_func = F_DIV;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mHi = '0;
    mLo = '0;
    @(negedge clk);
    checkValue("midrst in_ready", in_ready, 1'b1);
    checkValue("midrst hi", hi, 32'd0);
    checkValue("midrst lo", lo, 32'd0);
    ovSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ovSeen++;
    end
    checkValue("midrst no out_valid", 64'(ovSeen), 64'd0);
    runOp("mfhi after rst", F_MFHI, 32'h0, 32'h0);
    runOp("add after rst", F_ADD, 32'd20, 32'd22);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
